// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised loadable up/down modulo counter.
//
// Counts over 0..MODULUS-1. At the end of the range it either wraps modulo MODULUS
// or saturates, depending on sat_i. Reaching the end of the range while counting
// sets a sticky overflow flag. That flag stays set until it is cleared.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (count <= RESET_VAL, ovf <= 0)
//   en_i       count enable
//   load_i     synchronous parallel load of data_i (wins over en_i)
//   data_i     load value; values >= MODULUS are clamped to MODULUS-1
//   up_i       direction: 1 = increment, 0 = decrement
//   sat_i      end mode: 1 = saturate, 0 = wrap
//   clr_ovf_i  synchronous clear of ovf_o (an end-event in the same cycle wins)
//   count_o    registered count
//   tc_o       combinational terminal count: asserted in the cycle before a wrap/saturate
//   ovf_o      registered sticky overflow/underflow flag
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o
);

  // MODULUS can be 2^WIDTH, which does not fit in WIDTH bits. All range logic is
  // therefore written in terms of the largest legal count.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_end;
  logic             end_event;
  logic [WIDTH-1:0] load_val;

  // End value depends on the current direction.
  assign at_end    = up_i ? (count_q == MaxVal) : (count_q == '0);
  assign end_event = en_i & ~load_i & at_end;

  // Compare against MaxVal instead of MODULUS so the comparison never needs WIDTH+1 bits.
  assign load_val  = (data_i > MaxVal) ? MaxVal : data_i;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val;
    end else if (en_i) begin
      if (at_end) begin
        if (!sat_i) begin
          count_d = up_i ? '0 : MaxVal;
        end
      end else begin
        count_d = up_i ? (count_q + One) : (count_q - One);
      end
    end
  end

  // A set from an end-event wins over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (end_event) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RstVal;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign tc_o    = end_event;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Testbench for updown_mod_counter. It drives a MODULUS=10 instance and a
// MODULUS=16 instance from shared inputs. Expected count/ovf values are queued
// when stimulus is applied and popped after the clock edge.
module tb_updown_mod_counter;

  localparam int unsigned W = 4;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         en      = 1'b0;
  logic         load    = 1'b0;
  logic [W-1:0] data    = '0;
  logic         up      = 1'b1;
  logic         sat     = 1'b0;
  logic         clr_ovf = 1'b0;

  logic [W-1:0] count10, count16;
  logic         tc10, tc16, ovf10, ovf16;

  typedef struct packed {
    logic [W-1:0] count;
    logic         ovf;
  } exp_t;

  // One stimulus cycle plus the expected tc (before the edge) and count/ovf (after it).
  typedef struct packed {
    logic         ld;
    logic [W-1:0] d;
    logic         e;
    logic         u;
    logic         s;
    logic         c;
    logic         tc;
    logic [W-1:0] cnt;
    logic         ov;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb16_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  updown_mod_counter #(.WIDTH(W), .MODULUS(10), .RESET_VAL(0)) u_dut10 (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .load_i    (load),
    .data_i    (data),
    .up_i      (up),
    .sat_i     (sat),
    .clr_ovf_i (clr_ovf),
    .count_o   (count10),
    .tc_o      (tc10),
    .ovf_o     (ovf10)
  );

  updown_mod_counter #(.WIDTH(W), .MODULUS(16), .RESET_VAL(0)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .load_i    (load),
    .data_i    (data),
    .up_i      (up),
    .sat_i     (sat),
    .clr_ovf_i (clr_ovf),
    .count_o   (count16),
    .tc_o      (tc16),
    .ovf_o     (ovf16)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t vec(bit ld, int d, bit e, bit u, bit s, bit c,
                               bit tc, int cnt, bit ov);
    vec_t v;
    v.ld  = ld;
    v.d   = W'(d);
    v.e   = e;
    v.u   = u;
    v.s   = s;
    v.c   = c;
    v.tc  = tc;
    v.cnt = W'(cnt);
    v.ov  = ov;
    return v;
  endfunction

  task automatic test_reset();
    exp_t got;
    #2;
    sb_q.push_back('{count: 4'd0, ovf: 1'b0});
    got = sb_q.pop_front();
    n_tests++;
    if (count10 !== got.count || ovf10 !== got.ovf) begin
      n_fail++;
      $display("FAIL reset_initial: got count=%0d ovf=%b required count=%0d ovf=%b",
               count10, ovf10, got.count, got.ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    sb_q.push_back('{count: 4'd3, ovf: 1'b0});
    got = sb_q.pop_front();
    n_tests++;
    if (count10 !== got.count) begin
      n_fail++;
      $display("FAIL reset_precount: got count=%0d required %0d", count10, got.count);
    end
    // Assert reset away from any edge; outputs must clear without a clock.
    #3 rst = 1'b1;
    sb_q.push_back('{count: 4'd0, ovf: 1'b0});
    #1;
    got = sb_q.pop_front();
    n_tests++;
    if (count10 !== got.count || ovf10 !== got.ovf) begin
      n_fail++;
      $display("FAIL reset_async: got count=%0d ovf=%b required count=%0d ovf=%b",
               count10, ovf10, got.count, got.ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_count_up();
    exp_t got;
    logic exp_tc;
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_tc = ((i % 10) == 9);
      sb_q.push_back('{count: 4'((i + 1) % 10), ovf: (i >= 9)});
      #1;
      n_tests++;
      if (tc10 !== exp_tc) begin
        n_fail++;
        $display("FAIL count_up_tc[%0d]: got %b required %b", i, tc10, exp_tc);
      end
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_tests++;
      if (count10 !== got.count || ovf10 !== got.ovf) begin
        n_fail++;
        $display("FAIL count_up[%0d]: got count=%0d ovf=%b required count=%0d ovf=%b",
                 i, count10, ovf10, got.count, got.ovf);
      end
    end
  endtask

  task automatic run_vectors10(input string name, input vec_t v[$]);
    exp_t got;
    foreach (v[i]) begin
      load = v[i].ld; data = v[i].d; en = v[i].e; up = v[i].u; sat = v[i].s;
      clr_ovf = v[i].c;
      sb_q.push_back('{count: v[i].cnt, ovf: v[i].ov});
      #1;
      n_tests++;
      if (tc10 !== v[i].tc) begin
        n_fail++;
        $display("FAIL %s_tc[%0d]: got %b required %b", name, i, tc10, v[i].tc);
      end
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_tests++;
      if (count10 !== got.count || ovf10 !== got.ovf) begin
        n_fail++;
        $display("FAIL %s[%0d]: got count=%0d ovf=%b required count=%0d ovf=%b",
                 name, i, count10, ovf10, got.count, got.ovf);
      end
    end
    load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_down();
    vec_t v[$];
    v.push_back(vec(1, 2, 0, 0, 0, 1,  0, 2, 0));
    v.push_back(vec(0, 0, 1, 0, 0, 0,  0, 1, 0));
    v.push_back(vec(0, 0, 1, 0, 0, 0,  0, 0, 0));
    v.push_back(vec(0, 0, 1, 0, 0, 0,  1, 9, 1));
    v.push_back(vec(0, 0, 1, 0, 0, 0,  0, 8, 1));
    v.push_back(vec(0, 0, 1, 0, 0, 1,  0, 7, 0));
    run_vectors10("down", v);
  endtask

  task automatic test_saturate();
    vec_t v[$];
    v.push_back(vec(1, 8, 1, 1, 1, 1,  0, 8, 0));
    v.push_back(vec(0, 0, 1, 1, 1, 0,  0, 9, 0));
    v.push_back(vec(0, 0, 1, 1, 1, 0,  1, 9, 1));
    v.push_back(vec(0, 0, 1, 1, 1, 0,  1, 9, 1));
    v.push_back(vec(0, 0, 1, 1, 1, 0,  1, 9, 1));
    v.push_back(vec(0, 0, 1, 0, 1, 0,  0, 8, 1));
    v.push_back(vec(1, 1, 0, 0, 1, 1,  0, 1, 0));
    v.push_back(vec(0, 0, 1, 0, 1, 0,  0, 0, 0));
    v.push_back(vec(0, 0, 1, 0, 1, 1,  1, 0, 1));
    run_vectors10("saturate", v);
  endtask

  task automatic test_load();
    vec_t v[$];
    v.push_back(vec(1, 12, 1, 1, 0, 0,  0, 9, 1));
    v.push_back(vec(0, 0,  0, 1, 0, 1,  0, 9, 0));
    v.push_back(vec(1, 3,  1, 1, 0, 0,  0, 3, 0));
    v.push_back(vec(1, 15, 0, 0, 0, 0,  0, 9, 0));
    v.push_back(vec(1, 3,  0, 1, 0, 0,  0, 3, 0));
    run_vectors10("load", v);
  endtask

  task automatic test_simultaneous();
    vec_t v[$];
    exp_t got;
    v.push_back(vec(1, 9, 0, 1, 0, 0,  0, 9, 0));
    v.push_back(vec(0, 0, 1, 1, 0, 1,  1, 0, 1));
    run_vectors10("set_wins", v);
    load = 1'b1; data = 4'd5; en = 1'b1;
    #3 rst = 1'b1;
    sb_q.push_back('{count: 4'd0, ovf: 1'b0});
    #1;
    got = sb_q.pop_front();
    n_tests++;
    if (count10 !== got.count || ovf10 !== got.ovf) begin
      n_fail++;
      $display("FAIL rst_with_load_async: got count=%0d ovf=%b required count=%0d ovf=%b",
               count10, ovf10, got.count, got.ovf);
    end
    sb_q.push_back('{count: 4'd0, ovf: 1'b0});
    @(posedge clk); #1;
    got = sb_q.pop_front();
    n_tests++;
    if (count10 !== got.count || ovf10 !== got.ovf) begin
      n_fail++;
      $display("FAIL rst_with_load_edge: got count=%0d ovf=%b required count=%0d ovf=%b",
               count10, ovf10, got.count, got.ovf);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
    sb_q.push_back('{count: 4'd0, ovf: 1'b0});
    @(posedge clk); #1;
    got = sb_q.pop_front();
    n_tests++;
    if (count10 !== got.count || ovf10 !== got.ovf) begin
      n_fail++;
      $display("FAIL rst_release: got count=%0d ovf=%b required count=%0d ovf=%b",
               count10, ovf10, got.count, got.ovf);
    end
  endtask

  task automatic test_hold();
    vec_t v[$];
    v.push_back(vec(1, 7, 0, 1, 0, 0,  0, 7, 0));
    v.push_back(vec(0, 0, 0, 1, 0, 0,  0, 7, 0));
    v.push_back(vec(0, 0, 0, 0, 0, 0,  0, 7, 0));
    v.push_back(vec(0, 0, 0, 1, 1, 0,  0, 7, 0));
    v.push_back(vec(0, 0, 0, 0, 1, 0,  0, 7, 0));
    v.push_back(vec(0, 0, 0, 1, 0, 0,  0, 7, 0));
    v.push_back(vec(1, 9, 0, 1, 0, 0,  0, 9, 0));
    v.push_back(vec(0, 0, 0, 1, 0, 0,  0, 9, 0));
    run_vectors10("hold", v);
  endtask

  task automatic test_mod16();
    vec_t v[$];
    exp_t got;
    v.push_back(vec(1, 15, 0, 1, 0, 1,  0, 15, 0));
    v.push_back(vec(0, 0,  1, 1, 0, 0,  1, 0,  1));
    v.push_back(vec(0, 0,  1, 1, 0, 0,  0, 1,  1));
    v.push_back(vec(0, 0,  1, 0, 0, 1,  0, 0,  0));
    v.push_back(vec(0, 0,  1, 0, 0, 0,  1, 15, 1));
    v.push_back(vec(0, 0,  1, 1, 1, 0,  1, 15, 1));
    foreach (v[i]) begin
      load = v[i].ld; data = v[i].d; en = v[i].e; up = v[i].u; sat = v[i].s;
      clr_ovf = v[i].c;
      sb16_q.push_back('{count: v[i].cnt, ovf: v[i].ov});
      #1;
      n_tests++;
      if (tc16 !== v[i].tc) begin
        n_fail++;
        $display("FAIL mod16_tc[%0d]: got %b required %b", i, tc16, v[i].tc);
      end
      @(posedge clk); #1;
      got = sb16_q.pop_front();
      n_tests++;
      if (count16 !== got.count || ovf16 !== got.ovf) begin
        n_fail++;
        $display("FAIL mod16[%0d]: got count=%0d ovf=%b required count=%0d ovf=%b",
                 i, count16, ovf16, got.count, got.ovf);
      end
    end
    load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down();
    test_saturate();
    test_load();
    test_simultaneous();
    test_hold();
    test_mod16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
